// File: rtl/tile_pkg.sv
// Shared parameters, state encoding and address helpers for the tile write path.
// Tile addresses are {row, col}, with the column in the low bits.
package tile_pkg;

  localparam int COLS       = 160;
  localparam int ROWS       = 45;
  localparam int COL_BITS   = 8;
  localparam int ROW_BITS   = 6;
  localparam int ADDR_WIDTH = ROW_BITS + COL_BITS;
  localparam int DATA_WIDTH = 8;

  localparam logic [DATA_WIDTH-1:0] CLEAR_CHAR = 8'h00;

  localparam logic [COL_BITS-1:0] COL_LIM  = COL_BITS'(COLS);
  localparam logic [ROW_BITS-1:0] ROW_LIM  = ROW_BITS'(ROWS);
  localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(COLS - 1);
  localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(ROWS - 1);

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_t;

  function automatic logic [ADDR_WIDTH-1:0] tile_addr(
    input logic [ROW_BITS-1:0] row,
    input logic [COL_BITS-1:0] col
  );
    return {row, col};
  endfunction

endpackage

// File: rtl/tile_clear_sweeper.sv
// Row/column walker for the clear sweep.
// Visits every visible tile in order, with the column changing fastest.
module tile_clear_sweeper
  import tile_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                advance,
  output logic [ROW_BITS-1:0] row,
  output logic [COL_BITS-1:0] col,
  output logic                last
);

  logic [ROW_BITS-1:0] row_q, row_d;
  logic [COL_BITS-1:0] col_q, col_d;

  assign row  = row_q;
  assign col  = col_q;
  assign last = (row_q == ROW_LAST) && (col_q == COL_LAST);

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (start) begin
      row_d = '0;
      col_d = '0;
    end else if (advance) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/tile_write_scheduler.sv
// Owns tile BRAM port A: round-robin between keyboard and button writers,
// drops out-of-range tiles, and runs a full-screen clear sweep on request.
module tile_write_scheduler
  import tile_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_req,
  input  logic                  kb_valid,
  input  logic [ADDR_WIDTH-1:0] kb_addr,
  input  logic [DATA_WIDTH-1:0] kb_data,
  output logic                  kb_ready,
  input  logic                  btn_valid,
  input  logic [ADDR_WIDTH-1:0] btn_addr,
  input  logic [DATA_WIDTH-1:0] btn_data,
  output logic                  btn_ready,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_data,
  output logic                  clear_busy,
  output logic                  clear_done,
  output logic                  addr_err
);

  state_t                state_q, state_d;
  logic                  prio_btn_q, prio_btn_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  sw_start, sw_adv, sw_last;
  logic [ROW_BITS-1:0]   sw_row;
  logic [COL_BITS-1:0]   sw_col;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  in_range;

  tile_clear_sweeper u_sweep (
    .clk     (clk),
    .rst     (rst),
    .start   (sw_start),
    .advance (sw_adv),
    .row     (sw_row),
    .col     (sw_col),
    .last    (sw_last)
  );

  assign sel_addr = kb_ready ? kb_addr : btn_addr;
  assign sel_data = kb_ready ? kb_data : btn_data;
  assign in_range = (sel_addr[COL_BITS-1:0] < COL_LIM) &&
                    (sel_addr[ADDR_WIDTH-1:COL_BITS] < ROW_LIM);

  always_comb begin
    state_d    = state_q;
    prio_btn_d = prio_btn_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    kb_ready   = 1'b0;
    btn_ready  = 1'b0;
    sw_start   = 1'b0;
    sw_adv     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // busy_q still high here means the final sweep write is on the bus
        done_d = busy_q;
        if (!busy_q && clear_req) begin
          state_d  = S_CLEAR;
          sw_start = 1'b1;
        end else if (!busy_q) begin
          kb_ready  = kb_valid && (!btn_valid || !prio_btn_q);
          btn_ready = btn_valid && !kb_ready;
          if (kb_ready || btn_ready) begin
            prio_btn_d = kb_ready;
            if (in_range) begin
              we_d   = 1'b1;
              addr_d = sel_addr;
              data_d = sel_data;
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end
      S_CLEAR: begin
        we_d   = 1'b1;
        addr_d = tile_addr(sw_row, sw_col);
        data_d = CLEAR_CHAR;
        busy_d = 1'b1;
        sw_adv = 1'b1;
        if (sw_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      prio_btn_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      prio_btn_q <= prio_btn_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bram_we    = we_q;
  assign bram_addr  = addr_q;
  assign bram_data  = data_q;
  assign clear_busy = busy_q;
  assign clear_done = done_q;
  assign addr_err   = err_q;

endmodule
